// File: rtl/cvxif_copro_lsu.sv
// Coprocessor-side load/store unit: one op at a time, aligned onto the CV-X-IF
// x_mem request/result channels, with aligned load data or store completion to writeback.
module cvxif_copro_lsu #(
   parameter int unsigned XLEN       = 32,
   parameter int unsigned IdWidth    = 4,
   parameter int unsigned TimeoutCyc = 1023
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic               op_valid_i,
   output logic               op_ready_o,
   input  logic               op_we_i,
   input  logic [1:0]         op_size_i,
   input  logic               op_signed_i,
   input  logic [XLEN-1:0]    op_addr_i,
   input  logic [XLEN-1:0]    op_wdata_i,
   input  logic [IdWidth-1:0] op_id_i,
   output logic               x_mem_valid_o,
   input  logic               x_mem_ready_i,
   output logic [XLEN-1:0]    x_mem_addr_o,
   output logic               x_mem_we_o,
   output logic [3:0]         x_mem_be_o,
   output logic [XLEN-1:0]    x_mem_wdata_o,
   output logic [IdWidth-1:0] x_mem_id_o,
   input  logic               x_mem_result_valid_i,
   input  logic [IdWidth-1:0] x_mem_result_id_i,
   input  logic [XLEN-1:0]    x_mem_result_rdata_i,
   input  logic               x_mem_result_err_i,
   output logic               done_valid_o,
   output logic [IdWidth-1:0] done_id_o,
   output logic [XLEN-1:0]    done_rdata_o,
   output logic               done_err_o
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_RESP = 2'd2,
      ST_DONE = 2'd3
   } state_e;

   localparam int unsigned CntW       = (TimeoutCyc > 0) ? $clog2(TimeoutCyc + 1) : 1;
   localparam int unsigned CntLastInt = (TimeoutCyc > 0) ? (TimeoutCyc - 1) : 0;
   localparam logic [CntW-1:0] CntLast = CntW'(CntLastInt);
   localparam logic [CntW-1:0] CntOne  = CntW'(1);
   localparam bit TimeoutEn = (TimeoutCyc != 0);

   state_e             state_r;
   logic [CntW-1:0]    cnt_r;
   logic               we_r;
   logic [1:0]         size_r;
   logic               signed_r;
   logic [1:0]         off_r;
   logic [IdWidth-1:0] id_r;

   function automatic logic [3:0] calc_be(input logic [1:0] size, input logic [1:0] off);
      logic [3:0] mask;
      case (size)
         2'd0:    mask = 4'b0001;
         2'd1:    mask = 4'b0011;
         2'd2:    mask = 4'b1111;
         default: mask = 4'b0000;
      endcase
      return mask << off;
   endfunction

   function automatic logic op_illegal(input logic [1:0] size, input logic [1:0] off);
      case (size)
         2'd0:    return 1'b0;
         2'd1:    return off[0];
         2'd2:    return (off != 2'b00);
         default: return 1'b1;
      endcase
   endfunction

   // Move the addressed lane down to bit 0, then truncate and extend to the access size.
   function automatic logic [XLEN-1:0] align_load(input logic [XLEN-1:0] rdata, input logic [1:0] off,
                                                  input logic [1:0] size, input logic sgn);
      logic [XLEN-1:0] sh;
      sh = rdata >> {off, 3'b000};
      case (size)
         2'd0:    return {{(XLEN-8){sgn & sh[7]}}, sh[7:0]};
         2'd1:    return {{(XLEN-16){sgn & sh[15]}}, sh[15:0]};
         default: return sh;
      endcase
   endfunction

   // Only the idle state can take a new op, so at most one transaction is ever outstanding.
   assign op_ready_o = (state_r == ST_IDLE);

   // Control FSM with all request and completion outputs registered.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_r       <= ST_IDLE;
         cnt_r         <= '0;
         we_r          <= 1'b0;
         size_r        <= 2'd0;
         signed_r      <= 1'b0;
         off_r         <= 2'd0;
         id_r          <= '0;
         x_mem_valid_o <= 1'b0;
         x_mem_addr_o  <= '0;
         x_mem_we_o    <= 1'b0;
         x_mem_be_o    <= 4'b0000;
         x_mem_wdata_o <= '0;
         x_mem_id_o    <= '0;
         done_valid_o  <= 1'b0;
         done_id_o     <= '0;
         done_rdata_o  <= '0;
         done_err_o    <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (op_valid_i) begin
                  we_r     <= op_we_i;
                  size_r   <= op_size_i;
                  signed_r <= op_signed_i;
                  off_r    <= op_addr_i[1:0];
                  id_r     <= op_id_i;
                  if (op_illegal(op_size_i, op_addr_i[1:0])) begin
                     done_valid_o <= 1'b1;
                     done_id_o    <= op_id_i;
                     done_rdata_o <= '0;
                     done_err_o   <= 1'b1;
                     state_r      <= ST_DONE;
                  end else begin
                     x_mem_valid_o <= 1'b1;
                     x_mem_addr_o  <= op_addr_i;
                     x_mem_we_o    <= op_we_i;
                     x_mem_be_o    <= calc_be(op_size_i, op_addr_i[1:0]);
                     x_mem_wdata_o <= op_wdata_i << {op_addr_i[1:0], 3'b000};
                     x_mem_id_o    <= op_id_i;
                     state_r       <= ST_REQ;
                  end
               end else begin
                  state_r <= ST_IDLE;
               end
            end
            ST_REQ: begin
               if (x_mem_ready_i) begin
                  x_mem_valid_o <= 1'b0;
                  cnt_r         <= '0;
                  state_r       <= ST_RESP;
               end else begin
                  state_r <= ST_REQ;
               end
            end
            ST_RESP: begin
               // A matching result wins over a timeout expiring in the same cycle.
               if (x_mem_result_valid_i && (x_mem_result_id_i == id_r)) begin
                  done_valid_o <= 1'b1;
                  done_id_o    <= id_r;
                  done_rdata_o <= we_r ? '0 : align_load(x_mem_result_rdata_i, off_r, size_r, signed_r);
                  done_err_o   <= x_mem_result_err_i;
                  state_r      <= ST_DONE;
               end else if (TimeoutEn && (cnt_r == CntLast)) begin
                  done_valid_o <= 1'b1;
                  done_id_o    <= id_r;
                  done_rdata_o <= '0;
                  done_err_o   <= 1'b1;
                  state_r      <= ST_DONE;
               end else begin
                  cnt_r   <= cnt_r + CntOne;
                  state_r <= ST_RESP;
               end
            end
            ST_DONE: begin
               done_valid_o <= 1'b0;
               state_r      <= ST_IDLE;
            end
            default: begin
               x_mem_valid_o <= 1'b0;
               done_valid_o  <= 1'b0;
               state_r       <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cvxif_copro_lsu.sv
// Directed bench for cvxif_copro_lsu: hand-computed vectors for loads, stores,
// misaligned ops, id filtering, timeout and mid-transaction reset.
module tb_cvxif_copro_lsu;

   logic        clk_i = 1'b0;
   logic        rst_ni;
   logic        op_valid_i;
   logic        op_ready_o;
   logic        op_we_i;
   logic [1:0]  op_size_i;
   logic        op_signed_i;
   logic [31:0] op_addr_i;
   logic [31:0] op_wdata_i;
   logic [3:0]  op_id_i;
   logic        x_mem_valid_o;
   logic        x_mem_ready_i;
   logic [31:0] x_mem_addr_o;
   logic        x_mem_we_o;
   logic [3:0]  x_mem_be_o;
   logic [31:0] x_mem_wdata_o;
   logic [3:0]  x_mem_id_o;
   logic        x_mem_result_valid_i;
   logic [3:0]  x_mem_result_id_i;
   logic [31:0] x_mem_result_rdata_i;
   logic        x_mem_result_err_i;
   logic        done_valid_o;
   logic [3:0]  done_id_o;
   logic [31:0] done_rdata_o;
   logic        done_err_o;

   int total = 0;
   int bad   = 0;

   cvxif_copro_lsu #(.XLEN(32), .IdWidth(4), .TimeoutCyc(8)) dut (
      .clk_i                (clk_i),
      .rst_ni               (rst_ni),
      .op_valid_i           (op_valid_i),
      .op_ready_o           (op_ready_o),
      .op_we_i              (op_we_i),
      .op_size_i            (op_size_i),
      .op_signed_i          (op_signed_i),
      .op_addr_i            (op_addr_i),
      .op_wdata_i           (op_wdata_i),
      .op_id_i              (op_id_i),
      .x_mem_valid_o        (x_mem_valid_o),
      .x_mem_ready_i        (x_mem_ready_i),
      .x_mem_addr_o         (x_mem_addr_o),
      .x_mem_we_o           (x_mem_we_o),
      .x_mem_be_o           (x_mem_be_o),
      .x_mem_wdata_o        (x_mem_wdata_o),
      .x_mem_id_o           (x_mem_id_o),
      .x_mem_result_valid_i (x_mem_result_valid_i),
      .x_mem_result_id_i    (x_mem_result_id_i),
      .x_mem_result_rdata_i (x_mem_result_rdata_i),
      .x_mem_result_err_i   (x_mem_result_err_i),
      .done_valid_o         (done_valid_o),
      .done_id_o            (done_id_o),
      .done_rdata_o         (done_rdata_o),
      .done_err_o           (done_err_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic cyc();
      @(posedge clk_i);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic drive_op(input logic we, input logic [1:0] size, input logic sgn,
                           input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] id);
      op_valid_i  = 1'b1;
      op_we_i     = we;
      op_size_i   = size;
      op_signed_i = sgn;
      op_addr_i   = addr;
      op_wdata_i  = wdata;
      op_id_i     = id;
   endtask

   // Full legal transaction: request checks, optional stall, optional ignored results, completion checks.
   task automatic run_op(input string tag, input logic we, input logic [1:0] size, input logic sgn,
                         input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] id,
                         input int rdy_wait, input int resp_wait, input logic bogus, input logic early,
                         input logic [31:0] rdata, input logic err,
                         input logic [3:0] exp_be, input logic [31:0] exp_wdata, input logic [31:0] exp_rdata);
      drive_op(we, size, sgn, addr, wdata, id);
      cyc();
      op_valid_i = 1'b0;
      chk({tag, ".req_valid"}, x_mem_valid_o, 32'd1);
      chk({tag, ".op_ready"}, op_ready_o, 32'd0);
      chk({tag, ".addr"}, x_mem_addr_o, addr);
      chk({tag, ".we"}, x_mem_we_o, we);
      chk({tag, ".be"}, x_mem_be_o, exp_be);
      chk({tag, ".wdata"}, x_mem_wdata_o, exp_wdata);
      chk({tag, ".req_id"}, x_mem_id_o, id);
      for (int i = 0; i < rdy_wait; i++) begin
         cyc();
         chk({tag, ".held_valid"}, x_mem_valid_o, 32'd1);
         chk({tag, ".held_be"}, x_mem_be_o, exp_be);
         chk({tag, ".held_wdata"}, x_mem_wdata_o, exp_wdata);
      end
      x_mem_ready_i = 1'b1;
      if (early) begin
         x_mem_result_valid_i = 1'b1;
         x_mem_result_id_i    = id;
         x_mem_result_rdata_i = 32'h5555_5555;
         x_mem_result_err_i   = 1'b1;
      end
      cyc();
      x_mem_ready_i        = 1'b0;
      x_mem_result_valid_i = 1'b0;
      x_mem_result_err_i   = 1'b0;
      chk({tag, ".req_dropped"}, x_mem_valid_o, 32'd0);
      for (int i = 0; i < resp_wait; i++) begin
         if (bogus && i == 0) begin
            x_mem_result_valid_i = 1'b1;
            x_mem_result_id_i    = id ^ 4'h7;
            x_mem_result_rdata_i = 32'h1111_1111;
         end
         cyc();
         x_mem_result_valid_i = 1'b0;
         chk({tag, ".no_early_done"}, done_valid_o, 32'd0);
      end
      x_mem_result_valid_i = 1'b1;
      x_mem_result_id_i    = id;
      x_mem_result_rdata_i = rdata;
      x_mem_result_err_i   = err;
      cyc();
      x_mem_result_valid_i = 1'b0;
      x_mem_result_err_i   = 1'b0;
      chk({tag, ".done_valid"}, done_valid_o, 32'd1);
      chk({tag, ".done_id"}, done_id_o, id);
      chk({tag, ".done_rdata"}, done_rdata_o, exp_rdata);
      chk({tag, ".done_err"}, done_err_o, err);
      cyc();
      chk({tag, ".done_pulse"}, done_valid_o, 32'd0);
      chk({tag, ".ready_back"}, op_ready_o, 32'd1);
   endtask

   task automatic bad_op(input string tag, input logic [1:0] size, input logic [31:0] addr, input logic [3:0] id);
      drive_op(1'b0, size, 1'b0, addr, 32'h0, id);
      cyc();
      op_valid_i = 1'b0;
      chk({tag, ".done_valid"}, done_valid_o, 32'd1);
      chk({tag, ".done_err"}, done_err_o, 32'd1);
      chk({tag, ".done_id"}, done_id_o, id);
      chk({tag, ".done_rdata"}, done_rdata_o, 32'd0);
      chk({tag, ".no_req"}, x_mem_valid_o, 32'd0);
      cyc();
      chk({tag, ".done_pulse"}, done_valid_o, 32'd0);
      chk({tag, ".no_req2"}, x_mem_valid_o, 32'd0);
      chk({tag, ".ready_back"}, op_ready_o, 32'd1);
   endtask

   initial begin
      rst_ni               = 1'b0;
      op_valid_i           = 1'b0;
      op_we_i              = 1'b0;
      op_size_i            = 2'd0;
      op_signed_i          = 1'b0;
      op_addr_i            = 32'h0;
      op_wdata_i           = 32'h0;
      op_id_i              = 4'h0;
      x_mem_ready_i        = 1'b0;
      x_mem_result_valid_i = 1'b0;
      x_mem_result_id_i    = 4'h0;
      x_mem_result_rdata_i = 32'h0;
      x_mem_result_err_i   = 1'b0;
      cyc();
      cyc();
      chk("rst.op_ready", op_ready_o, 32'd1);
      chk("rst.req_valid", x_mem_valid_o, 32'd0);
      chk("rst.be", x_mem_be_o, 32'd0);
      chk("rst.done_valid", done_valid_o, 32'd0);
      chk("rst.done_rdata", done_rdata_o, 32'd0);
      rst_ni = 1'b1;
      cyc();

      run_op("ldw", 1'b0, 2'd2, 1'b0, 32'h0000_1000, 32'h0, 4'h3, 0, 2, 1'b0, 1'b0,
             32'hDEAD_BEEF, 1'b0, 4'b1111, 32'h0, 32'hDEAD_BEEF);
      run_op("lbs", 1'b0, 2'd0, 1'b1, 32'h0000_1003, 32'h0, 4'h1, 0, 1, 1'b0, 1'b0,
             32'h80FF_FFFF, 1'b0, 4'b1000, 32'h0, 32'hFFFF_FF80);
      run_op("lbu", 1'b0, 2'd0, 1'b0, 32'h0000_1003, 32'h0, 4'h4, 1, 1, 1'b0, 1'b0,
             32'h80FF_FFFF, 1'b0, 4'b1000, 32'h0, 32'h0000_0080);
      run_op("lhs", 1'b0, 2'd1, 1'b1, 32'h0000_1002, 32'h0, 4'h6, 0, 0, 1'b0, 1'b0,
             32'h8001_0000, 1'b0, 4'b1100, 32'h0, 32'hFFFF_8001);
      run_op("sh", 1'b1, 2'd1, 1'b0, 32'h0000_2002, 32'h0000_ABCD, 4'h9, 3, 1, 1'b0, 1'b0,
             32'h1234_5678, 1'b0, 4'b1100, 32'hABCD_0000, 32'h0);
      run_op("idfilt", 1'b0, 2'd2, 1'b0, 32'h0000_4000, 32'h0, 4'h2, 0, 2, 1'b1, 1'b0,
             32'hCAFE_F00D, 1'b1, 4'b1111, 32'h0, 32'hCAFE_F00D);
      run_op("sb_early", 1'b1, 2'd0, 1'b0, 32'h0000_0011, 32'h1234_5677, 4'hC, 0, 1, 1'b0, 1'b1,
             32'hFFFF_FFFF, 1'b0, 4'b0010, 32'h3456_7700, 32'h0);

      bad_op("misw", 2'd2, 32'h0000_1001, 4'hA);
      bad_op("mish", 2'd1, 32'h0000_1001, 4'hB);
      bad_op("size3", 2'd3, 32'h0000_1000, 4'hD);

      // Timeout: grant, then no result; done must appear 8 edges after the grant edge.
      drive_op(1'b0, 2'd2, 1'b0, 32'h0000_3000, 32'h0, 4'h7);
      cyc();
      op_valid_i    = 1'b0;
      x_mem_ready_i = 1'b1;
      cyc();
      x_mem_ready_i = 1'b0;
      chk("tmo.granted", x_mem_valid_o, 32'd0);
      for (int k = 1; k < 8; k++) begin
         cyc();
         chk("tmo.wait", done_valid_o, 32'd0);
      end
      cyc();
      chk("tmo.done_valid", done_valid_o, 32'd1);
      chk("tmo.done_err", done_err_o, 32'd1);
      chk("tmo.done_id", done_id_o, 32'h7);
      chk("tmo.done_rdata", done_rdata_o, 32'd0);
      cyc();
      chk("tmo.ready_back", op_ready_o, 32'd1);

      // Reset while waiting for a result; the late result must not produce a completion.
      drive_op(1'b1, 2'd2, 1'b0, 32'h0000_5004, 32'h0BAD_F00D, 4'h5);
      cyc();
      op_valid_i    = 1'b0;
      x_mem_ready_i = 1'b1;
      cyc();
      x_mem_ready_i = 1'b0;
      cyc();
      rst_ni = 1'b0;
      #1;
      chk("mrst.op_ready", op_ready_o, 32'd1);
      chk("mrst.req_valid", x_mem_valid_o, 32'd0);
      chk("mrst.addr", x_mem_addr_o, 32'd0);
      chk("mrst.wdata", x_mem_wdata_o, 32'd0);
      chk("mrst.be", x_mem_be_o, 32'd0);
      chk("mrst.done_valid", done_valid_o, 32'd0);
      cyc();
      rst_ni               = 1'b1;
      x_mem_result_valid_i = 1'b1;
      x_mem_result_id_i    = 4'h5;
      x_mem_result_rdata_i = 32'h7777_7777;
      cyc();
      x_mem_result_valid_i = 1'b0;
      chk("mrst.no_done", done_valid_o, 32'd0);
      chk("mrst.idle", op_ready_o, 32'd1);
      cyc();
      chk("mrst.no_done2", done_valid_o, 32'd0);

      run_op("recover", 1'b0, 2'd1, 1'b0, 32'h0000_6000, 32'h0, 4'hE, 0, 1, 1'b0, 1'b0,
             32'h1234_F00D, 1'b0, 4'b0011, 32'h0, 32'h0000_F00D);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
